// File: rtl/proj_pkg.sv
// Shared constants, types and helpers for the streaming extender.
// One-hot base encoding used by the GFM matcher interface.
package proj_pkg;

    localparam int EXT_FRAG_SIZE  = 64;
    localparam int EXT_KMER_SIZE  = 16;
    localparam int EXT_PART_BASES = 8;
    localparam int EXT_PARTS      = EXT_FRAG_SIZE / EXT_PART_BASES;
    localparam int EXT_OFFSET     = (EXT_FRAG_SIZE - EXT_KMER_SIZE) >> 1;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ext_state_t;

    typedef logic [1:0] base_t;
    typedef logic [3:0] onehot_t;

    function automatic onehot_t base_to_onehot(input base_t b);
        onehot_t r;
        r = 4'b0000;
        case (b)
            2'b00:   r = 4'b0001;
            2'b01:   r = 4'b0010;
            2'b10:   r = 4'b0100;
            default: r = 4'b1000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/proj_extender_part_enc.sv
// Combinational one-hot encoder for one output part.
// Complements each base when reverse-complement is requested.
module proj_extender_part_enc
    import proj_pkg::*;
#(
    parameter int PART_BASES = EXT_PART_BASES
) (
    input  logic [PART_BASES*2-1:0] bases_i,
    input  logic                    rc_i,
    output logic [PART_BASES*4-1:0] gfm_o
);

    always_comb begin
        base_t b;
        gfm_o = '0;
        b     = 2'b00;
        for (int j = 0; j < PART_BASES; j++) begin
            b = bases_i[j*2 +: 2];
            if (rc_i) b = ~b;
            gfm_o[j*4 +: 4] = base_to_onehot(b);
        end
    end

endmodule

// File: rtl/proj_extender_stream.sv
// Handshaked extender: one job in, PARTS beats out per valid index.
// Beats carry offset-corrected signed index and a one-hot fragment part.
module proj_extender_stream
    import proj_pkg::*;
#(
    parameter int FRAG_SIZE         = EXT_FRAG_SIZE,
    parameter int KMER_SIZE         = EXT_KMER_SIZE,
    parameter int INDICES_COUNT     = 8,
    parameter int INDICE_LEN        = 16,
    parameter int SIGNED_INDICE_LEN = 17,
    parameter int PART_BASES        = EXT_PART_BASES,
    parameter int BASE_LEN          = 2,
    parameter int ONE_HOT_LEN       = 4,
    localparam int FLB   = FRAG_SIZE * BASE_LEN,
    localparam int PARTS = FRAG_SIZE / PART_BASES,
    localparam int CW    = $clog2(INDICES_COUNT + 1),
    localparam int PW    = (PARTS > 1) ? $clog2(PARTS) : 1,
    localparam int IW    = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [FLB-1:0]                      in_fragment,
    input  logic [INDICES_COUNT*INDICE_LEN-1:0] in_kmer_indices,
    input  logic [CW-1:0]                       in_indices_cnt,
    input  logic                                in_rc,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [SIGNED_INDICE_LEN-1:0]        out_index,
    output logic                                out_neg,
    output logic [PART_BASES*ONE_HOT_LEN-1:0]   out_gfm,
    output logic [PW-1:0]                       out_part_idx,
    output logic                                out_first,
    output logic                                out_last
);

    localparam int OFFSET = (FRAG_SIZE - KMER_SIZE) >> 1;

    ext_state_t                        state_q, state_d;
    logic [PW-1:0]                     part_q, part_d;
    logic [IW-1:0]                     idx_q, idx_d;
    logic [FLB-1:0]                    frag_q, frag_d;
    logic [INDICES_COUNT*INDICE_LEN-1:0] inds_q, inds_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic                              rc_q, rc_d;

    logic [CW-1:0]                     cnt_sat;
    logic                              last_part;
    logic                              last_idx;
    logic [INDICE_LEN-1:0]             cur_ind;
    logic [SIGNED_INDICE_LEN-1:0]      index_raw;
    logic [PART_BASES*BASE_LEN-1:0]    sel_bases;
    logic [PART_BASES*ONE_HOT_LEN-1:0] gfm_raw;

    assign cnt_sat   = (in_indices_cnt > CW'(INDICES_COUNT))
                     ? CW'(INDICES_COUNT) : in_indices_cnt;
    assign last_part = (part_q == PW'(PARTS - 1));
    assign last_idx  = (CW'(idx_q) == cnt_q - CW'(1));

    always_comb begin
        state_d  = state_q;
        part_d   = part_q;
        idx_d    = idx_q;
        frag_d   = frag_q;
        inds_d   = inds_q;
        cnt_d    = cnt_q;
        rc_d     = rc_q;
        in_ready = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    frag_d = in_fragment;
                    inds_d = in_kmer_indices;
                    cnt_d  = cnt_sat;
                    rc_d   = in_rc;
                    part_d = '0;
                    idx_d  = '0;
                    if (cnt_sat != '0) state_d = STREAM;
                end
            end
            default: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (last_part) begin
                        part_d = '0;
                        if (last_idx) begin
                            idx_d   = '0;
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        part_d = part_q + PW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            part_q  <= '0;
            idx_q   <= '0;
            frag_q  <= '0;
            inds_q  <= '0;
            cnt_q   <= '0;
            rc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            part_q  <= part_d;
            idx_q   <= idx_d;
            frag_q  <= frag_d;
            inds_q  <= inds_d;
            cnt_q   <= cnt_d;
            rc_q    <= rc_d;
        end
    end

    // Reverse-complement walks the fragment from its far end.
    always_comb begin
        int bi;
        bi        = 0;
        sel_bases = '0;
        for (int j = 0; j < PART_BASES; j++) begin
            bi = int'(part_q) * PART_BASES + j;
            if (rc_q) bi = FRAG_SIZE - 1 - bi;
            sel_bases[j*BASE_LEN +: BASE_LEN] = frag_q[bi*BASE_LEN +: BASE_LEN];
        end
    end

    proj_extender_part_enc #(
        .PART_BASES(PART_BASES)
    ) u_enc (
        .bases_i(sel_bases),
        .rc_i   (rc_q),
        .gfm_o  (gfm_raw)
    );

    assign cur_ind   = inds_q[int'(idx_q)*INDICE_LEN +: INDICE_LEN];
    assign index_raw = {1'b0, cur_ind} - SIGNED_INDICE_LEN'(OFFSET);

    assign out_index    = out_valid ? index_raw : '0;
    assign out_neg      = out_index[SIGNED_INDICE_LEN-1];
    assign out_gfm      = out_valid ? gfm_raw : '0;
    assign out_part_idx = out_valid ? part_q : '0;
    assign out_first    = out_valid && (part_q == '0);
    assign out_last     = out_valid && last_part && last_idx;

endmodule

// File: tb/tb_proj_extender_stream.sv
// Directed bench for proj_extender_stream with hand-computed beats.
// Drives and samples on the falling edge; DUT registers on the rising edge.
module tb_proj_extender_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_fragment;
    logic [127:0] in_kmer_indices;
    logic [3:0]   in_indices_cnt;
    logic         in_rc;
    logic         out_valid;
    logic         out_ready;
    logic [16:0]  out_index;
    logic         out_neg;
    logic [31:0]  out_gfm;
    logic [2:0]   out_part_idx;
    logic         out_first;
    logic         out_last;

    int vectors = 0;
    int miscompares = 0;

    logic [16:0]  exp_idx [8];
    logic [31:0]  exp_g0;
    logic [31:0]  exp_gn;

    always #5 clk = ~clk;

    proj_extender_stream dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_fragment    (in_fragment),
        .in_kmer_indices(in_kmer_indices),
        .in_indices_cnt (in_indices_cnt),
        .in_rc          (in_rc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_index      (out_index),
        .out_neg        (out_neg),
        .out_gfm        (out_gfm),
        .out_part_idx   (out_part_idx),
        .out_first      (out_first),
        .out_last       (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch a job (inputs preset by caller) and check every beat.
    task automatic run_job(input string tag, input int n,
                           input bit toggle, input int abort_part);
        int  part = 0;
        int  ix = 0;
        int  done = 0;
        int  cyc = 0;
        bit  first = 1'b1;
        bit  aborted = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while (done < n * 8 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (first) begin
                in_valid = 1'b0;
                chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
                first = 1'b0;
            end
            chk({tag, ".valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".index"}, 32'(out_index), 32'(exp_idx[ix]));
            chk({tag, ".neg"}, 32'(out_neg), 32'(exp_idx[ix][16]));
            chk({tag, ".gfm"}, out_gfm, (part == 0) ? exp_g0 : exp_gn);
            chk({tag, ".part"}, 32'(out_part_idx), 32'(part));
            chk({tag, ".first"}, 32'(out_first), 32'(part == 0));
            chk({tag, ".last"}, 32'(out_last),
                32'(part == 7 && ix == n - 1));
            if (part == abort_part) begin
                rst = 1'b1;
                aborted = 1'b1;
                break;
            end
            out_ready = toggle ? ~out_ready : 1'b1;
            if (out_ready) begin
                done++;
                if (part == 7) begin
                    part = 0;
                    ix++;
                end else begin
                    part++;
                end
            end
        end
        if (!aborted) chk({tag, ".transfers"}, 32'(done), 32'(n * 8));
        @(negedge clk);
        out_ready = 1'b1;
        chk({tag, ".end_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".end_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, ".end_gfm"}, out_gfm, 32'd0);
        chk({tag, ".end_index"}, 32'(out_index), 32'd0);
    endtask

    initial begin
        logic [127:0] f;
        rst             = 1'b1;
        in_valid        = 1'b0;
        in_fragment     = '0;
        in_kmer_indices = '0;
        in_indices_cnt  = '0;
        in_rc           = 1'b0;
        out_ready       = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.index", 32'(out_index), 32'd0);
        chk("reset.part", 32'(out_part_idx), 32'd0);
        rst = 1'b0;

        // Forward, base b = b mod 4, single index 100 -> 76.
        f = '0;
        for (int b = 0; b < 64; b++) f[b*2 +: 2] = 2'(b % 4);
        in_fragment        = f;
        in_kmer_indices    = '0;
        in_kmer_indices[15:0] = 16'd100;
        in_indices_cnt     = 4'd1;
        in_rc              = 1'b0;
        exp_idx[0]         = 17'd76;
        exp_g0             = 32'h8421_8421;
        exp_gn             = 32'h8421_8421;
        run_job("fwd", 1, 1'b0, -1);

        // Index below offset: 10 - 24 = -14.
        in_kmer_indices[15:0] = 16'd10;
        exp_idx[0]            = 17'h1FFF2;
        run_job("neg", 1, 1'b0, -1);

        // Three indices with toggling backpressure.
        in_kmer_indices[15:0]  = 16'd5;
        in_kmer_indices[31:16] = 16'd200;
        in_kmer_indices[47:32] = 16'd65535;
        in_indices_cnt         = 4'd3;
        exp_idx[0]             = 17'h1FFED;
        exp_idx[1]             = 17'd176;
        exp_idx[2]             = 17'd65511;
        run_job("multi_bp", 3, 1'b1, -1);

        // Reverse complement: all A except base 63 = C.
        f = '0;
        f[127:126] = 2'b01;
        in_fragment           = f;
        in_kmer_indices       = '0;
        in_kmer_indices[15:0] = 16'd24;
        in_indices_cnt        = 4'd1;
        in_rc                 = 1'b1;
        exp_idx[0]            = 17'd0;
        exp_g0                = 32'h8888_8884;
        exp_gn                = 32'h8888_8888;
        run_job("rc", 1, 1'b0, -1);

        // Empty job is dropped; in_ready stays high.
        in_indices_cnt = 4'd0;
        in_valid       = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("cnt0.in_ready", 32'(in_ready), 32'd1);
        chk("cnt0.valid", 32'(out_valid), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("cnt0.valid_hold", 32'(out_valid), 32'd0);
        end
        in_indices_cnt = 4'd1;
        run_job("after_cnt0", 1, 1'b0, -1);

        // Count above maximum saturates to 8 indices of 30 -> 6.
        in_rc = 1'b0;
        f = '0;
        for (int b = 0; b < 64; b++) f[b*2 +: 2] = 2'(b % 4);
        in_fragment = f;
        for (int i = 0; i < 8; i++) begin
            in_kmer_indices[i*16 +: 16] = 16'd30;
            exp_idx[i] = 17'd6;
        end
        in_indices_cnt = 4'd12;
        exp_g0 = 32'h8421_8421;
        exp_gn = 32'h8421_8421;
        run_job("sat", 8, 1'b0, -1);

        // Reset while beat 3 is presented, then a fresh job.
        in_indices_cnt = 4'd1;
        run_job("abort", 1, 1'b0, 3);
        rst = 1'b0;
        run_job("post_abort", 1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
